stream_mux_rr: RTL
==================

// Module: stream_mux_rr
// PURPOSE
//   Parametrised N:1 stream multiplexer with valid/ready handshake on every
//   channel and one registered output stage. Successor to the 4:1 dataflow mux:
//   generalised in channel count and width, adds fixed-select and round-robin modes.
//   Sits between N producer streams and one shared consumer (bus/FIFO port).
// PARAMETERS
//   NUM_CH   4                 number of input channels (>=2)
//   WIDTH    8                 data width per channel
//   SEL_W    $clog2(NUM_CH)    select / channel-id width (derived, do not override)
// PORTS
//   clk        in   1              clock, rising edge
//   rst_n      in   1              asynchronous reset, active low
//   mode       in   1              0 = fixed select, 1 = round-robin
//   sel        in   SEL_W          channel select, used in fixed mode only
//   in_valid   in   NUM_CH         per-channel valid
//   in_data    in   NUM_CH*WIDTH   channel i at [i*WIDTH +: WIDTH]
//   in_ready   out  NUM_CH         per-channel ready (one-hot or zero)
//   out_valid  out  1              output register holds a beat
//   out_data   out  WIDTH          registered data
//   out_ch     out  SEL_W          channel id of the beat in out_data
//   out_ready  in   1              consumer ready
// BEHAVIOUR
//   - Reset (rst_n=0, async): out_valid=0, out_data=0, out_ch=0, rr pointer=NUM_CH-1.
//     A beat held at reset is dropped. Outputs stay at reset values until the
//     first clk edge after release.
//   - load_en = !out_valid | out_ready. Output register loads only when load_en=1.
//   - Grant (combinational, at most one bit set):
//       fixed: grant[sel]=in_valid[sel]; sel>=NUM_CH -> no grant.
//       rr:    first valid channel in order ptr+1, ptr+2, ... wrapping mod NUM_CH.
//   - in_ready = grant & {NUM_CH{load_en}}. Transfer on in_valid[i]&in_ready[i].
//   - On transfer: out_data<=in_data[i], out_ch<=i, out_valid<=1; rr ptr<=i
//     (rr mode only; fixed mode leaves ptr unchanged).
//   - No transfer and out_ready=1 -> out_valid<=0 (out_data/out_ch hold).
//   - Latency 1 cycle input->output; throughput 1 beat/cycle when out_ready=1.
//   - Backpressure: out_valid=1 & out_ready=0 -> register, ptr and in_ready=0 hold.
//   - Simultaneous drain+load (out_valid=1, out_ready=1, grant) -> new beat loaded.
//   - mode/sel changes take effect on the same-cycle grant; ptr is retained
//     across mode switches.
//   - Pointer wrap: ptr=NUM_CH-1 -> search starts at 0.
//   - Non-power-of-2 NUM_CH: ids >= NUM_CH never granted or emitted.
// STRUCTURE
//   - stream_mux_pkg: MODE_FIXED=1'b0, MODE_RR=1'b1.
//   - Sub-module rr_arbiter #(NUM_CH): req, ptr -> one-hot grant + encoded index;
//     the top handles fixed mode, handshake, the output register and the ptr register.
// TESTING
//   1 Reset: assert rst_n=0 mid-beat -> out_valid=0, out_data=0, out_ch=0
//     immediately, with no clk edge.
//   2 Fixed: mode=0, sel=2, in_valid=4'b1111, data ch i=8'hA0+i, out_ready=1
//     -> from cycle 1, out_data=8'hA2, out_ch=2 every cycle; in_ready=4'b0100.
//   3 RR fairness: mode=1, all valid, out_ready=1 -> out_ch sequence
//     0,1,2,3,0,1,... back to back.
//   4 RR skip: in_valid=4'b1010 -> out_ch 1,3,1,3; then drop ch1 -> only 3.
//   5 Backpressure: out_ready=0 for 3 cycles with a beat held -> out_data and
//     out_ch stable, in_ready=0; out_ready=1 -> next beat the cycle after.
//   6 Fixed sel out of range: NUM_CH=3, sel=3 -> in_ready=0, out_valid falls
//     after drain.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared mode encodings for the round-robin stream multiplexer
package stream_mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant starting one past the last-granted channel
module rr_arbiter #(
  parameter int NUM_CH = 4,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  idx
);
  logic found;
  // scan ptr+1, ptr+2, ... wrapping, and take the first requester
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!found && req[(int'(ptr) + k) % NUM_CH]) begin
        found = 1'b1;
        grant[(int'(ptr) + k) % NUM_CH] = 1'b1;
        idx   = SEL_W'((int'(ptr) + k) % NUM_CH);
      end
    end
  end
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N:1 valid/ready stream mux with fixed or round-robin select and a registered output
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  input  logic                    out_ready
);
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [NUM_CH-1:0] rr_grant, fix_grant, grant;
  logic [SEL_W-1:0]  rr_idx, grant_idx;
  logic              load_en, xfer;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req   (in_valid),
    .ptr   (ptr_q),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  // fixed-mode grant; a select past the last channel matches nothing
  always_comb begin
    fix_grant = '0;
    for (int i = 0; i < NUM_CH; i++) fix_grant[i] = in_valid[i] && (sel == SEL_W'(i));
  end

  assign load_en   = !out_valid_q || out_ready;
  assign grant     = (mode == MODE_RR) ? rr_grant : fix_grant;
  assign grant_idx = (mode == MODE_RR) ? rr_idx : sel;
  assign in_ready  = grant & {NUM_CH{load_en}};
  assign xfer      = |in_ready;

  // load a granted beat, drain when consumed, otherwise hold
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
      out_ch_d    = grant_idx;
      ptr_d       = (mode == MODE_RR) ? grant_idx : ptr_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // output stage and round-robin pointer; pointer resets so channel 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= SEL_W'(NUM_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
endmodule
